pe_pkt_loader: RTL and testbench

//  Clocked packet source feeding the PE array. It builds the 34-bit NoC packets that each PE depacketizer consumes.

---
 rtl/pe_pkt_loader.sv | 193 +++++++++++++++++++
 tb/tb_pe_pkt_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pe_pkt_loader.sv
// PE-row packet source: keeps three kernel rows and, per accepted 5x5 spike timestep,
// streams the kernel packets (only when changed) followed by the five ifmap-row packets.
package pe_pkt_loader_pkg;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned TYPE_W    = 2;
  localparam int unsigned PAYLOAD_W = 24;
  localparam int unsigned PKT_W     = ADDR_W + ADDR_W + TYPE_W + PAYLOAD_W;

  typedef struct packed {
    logic [ADDR_W-1:0]    src;
    logic [ADDR_W-1:0]    dst;
    logic [TYPE_W-1:0]    ptype;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_t;
endpackage

module pe_pkt_loader
  import pe_pkt_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SRC_ADDR    = 4'b0000,
  parameter logic [ADDR_W-1:0] PE1_ADDR    = 4'b0010,
  parameter logic [ADDR_W-1:0] PE2_ADDR    = 4'b0110,
  parameter logic [ADDR_W-1:0] PE3_ADDR    = 4'b1010,
  parameter logic [TYPE_W-1:0] INPUT_TYPE  = 2'b00,
  parameter logic [TYPE_W-1:0] KERNEL_TYPE = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flt_we,
  input  logic [1:0]       flt_idx,
  input  logic [23:0]      flt_wdata,
  input  logic             ts_valid,
  output logic             ts_ready,
  input  logic [24:0]      ts_ifmap,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic [PKT_W-1:0] pkt_data,
  output logic             ts_done,
  output logic             busy
);

  localparam int unsigned KROW_W = 24;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned MAP_W  = 25;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {IDLE, KERNEL, IFMAP, DONE} state_t;

  state_t                   state_q, state_n;
  logic [CNT_W-1:0]         cnt_q, cnt_n;
  logic [2:0][KROW_W-1:0]   krow_q, krow_n;
  logic                     kdirty_q, kdirty_n;
  logic [MAP_W-1:0]         ifmap_q, ifmap_n;
  pkt_t                     pkt_q, pkt_n;
  logic                     pkt_valid_n, ts_done_n, ts_ready_n, busy_n;
  logic                     xfer;

  function automatic pkt_t make_pkt(input logic [ADDR_W-1:0] dst,
                                    input logic [TYPE_W-1:0] ptype,
                                    input logic [PAYLOAD_W-1:0] payload);
    pkt_t p;
    p.src     = SRC_ADDR;
    p.dst     = dst;
    p.ptype   = ptype;
    p.payload = payload;
    return p;
  endfunction

  function automatic pkt_t kernel_pkt(input logic [CNT_W-1:0] sel,
                                      input logic [2:0][KROW_W-1:0] krow);
    pkt_t p;
    case (sel)
      3'd0:    p = make_pkt(PE1_ADDR, KERNEL_TYPE, krow[0]);
      3'd1:    p = make_pkt(PE2_ADDR, KERNEL_TYPE, krow[1]);
      default: p = make_pkt(PE3_ADDR, KERNEL_TYPE, krow[2]);
    endcase
    return p;
  endfunction

  // Rows 2..4 all go to PE3; the row is zero-extended into the payload.
  function automatic pkt_t ifmap_pkt(input logic [CNT_W-1:0] sel,
                                     input logic [MAP_W-1:0] map);
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] dst;
    row = map[4:0];
    dst = PE1_ADDR;
    case (sel)
      3'd0:    begin row = map[4:0];   dst = PE1_ADDR; end
      3'd1:    begin row = map[9:5];   dst = PE2_ADDR; end
      3'd2:    begin row = map[14:10]; dst = PE3_ADDR; end
      3'd3:    begin row = map[19:15]; dst = PE3_ADDR; end
      default: begin row = map[24:20]; dst = PE3_ADDR; end
    endcase
    return make_pkt(dst, INPUT_TYPE, PAYLOAD_W'(row));
  endfunction

  assign xfer     = pkt_valid && pkt_ready;
  assign pkt_data = pkt_q;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      krow_q    <= '0;
      kdirty_q  <= 1'b1;
      ifmap_q   <= '0;
      pkt_q     <= '0;
      pkt_valid <= 1'b0;
      ts_done   <= 1'b0;
      ts_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      krow_q    <= krow_n;
      kdirty_q  <= kdirty_n;
      ifmap_q   <= ifmap_n;
      pkt_q     <= pkt_n;
      pkt_valid <= pkt_valid_n;
      ts_done   <= ts_done_n;
      ts_ready  <= ts_ready_n;
      busy      <= busy_n;
    end
  end

  // Next state; the next packet is loaded into the output register on each handshake.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    krow_n      = krow_q;
    kdirty_n    = kdirty_q;
    ifmap_n     = ifmap_q;
    pkt_n       = pkt_q;
    pkt_valid_n = pkt_valid;
    ts_done_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flt_we) begin
          case (flt_idx)
            2'd0:    begin krow_n[0] = flt_wdata; kdirty_n = 1'b1; end
            2'd1:    begin krow_n[1] = flt_wdata; kdirty_n = 1'b1; end
            2'd2:    begin krow_n[2] = flt_wdata; kdirty_n = 1'b1; end
            default: ;
          endcase
        end
        // A same-cycle kernel write is bypassed into the first kernel packet.
        if (ts_valid && ts_ready) begin
          ifmap_n     = ts_ifmap;
          cnt_n       = '0;
          pkt_valid_n = 1'b1;
          if (kdirty_n) begin
            state_n = KERNEL;
            pkt_n   = kernel_pkt(3'd0, krow_n);
          end else begin
            state_n = IFMAP;
            pkt_n   = ifmap_pkt(3'd0, ts_ifmap);
          end
        end
      end
      KERNEL: begin
        if (xfer) begin
          if (cnt_q == 3'd2) begin
            kdirty_n = 1'b0;
            cnt_n    = '0;
            state_n  = IFMAP;
            pkt_n    = ifmap_pkt(3'd0, ifmap_q);
          end else begin
            cnt_n = cnt_q + 3'd1;
            pkt_n = kernel_pkt(cnt_n, krow_q);
          end
        end
      end
      IFMAP: begin
        if (xfer) begin
          if (cnt_q == 3'd4) begin
            state_n     = DONE;
            pkt_valid_n = 1'b0;
            ts_done_n   = 1'b1;
          end else begin
            cnt_n = cnt_q + 3'd1;
            pkt_n = ifmap_pkt(cnt_n, ifmap_q);
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ts_ready_n = (state_n == IDLE);
    busy_n     = (state_n != IDLE);
  end

endmodule

// File: tb/tb_pe_pkt_loader.sv
// Randomised bench for pe_pkt_loader: a per-timestep packet list built from the routing
// rules is compared against every NoC handshake, plus latency, hold and reset checks.
module tb_pe_pkt_loader;
  localparam logic [3:0] SRC = 4'b0000;
  localparam logic [3:0] PE1 = 4'b0010;
  localparam logic [3:0] PE2 = 4'b0110;
  localparam logic [3:0] PE3 = 4'b1010;
  localparam logic [1:0] T_IN = 2'b00;
  localparam logic [1:0] T_K  = 2'b01;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flt_we = 1'b0;
  logic [1:0]  flt_idx = '0;
  logic [23:0] flt_wdata = '0;
  logic        ts_valid = 1'b0;
  logic        ts_ready;
  logic [24:0] ts_ifmap = '0;
  logic        pkt_valid;
  logic        pkt_ready = 1'b0;
  logic [33:0] pkt_data;
  logic        ts_done;
  logic        busy;

  pe_pkt_loader dut (
    .clk(clk), .reset(reset), .flt_we(flt_we), .flt_idx(flt_idx), .flt_wdata(flt_wdata),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_ifmap(ts_ifmap),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .ts_done(ts_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: kernel contents, dirty flag, and packets still owed to the NoC.
  logic [23:0] m_k [3];
  bit          m_dirty;
  logic [33:0] exp_q [$];
  logic [3:0]  k_dst [3] = '{PE1, PE2, PE3};
  logic [3:0]  i_dst [5] = '{PE1, PE2, PE3, PE3, PE3};

  int          ready_mode = 0;
  int          stall_at = -1;
  int          stall_left = 0;
  int          xfers = 0;
  bit          hold_v = 0;
  logic [33:0] hold_d = '0;
  bit          done_seen = 0;

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: choose pkt_ready, score a handshake, advance, then sample on the falling edge.
  task automatic tick();
    logic [33:0] exp;
    if (ready_mode == 0) pkt_ready = 1'b1;
    else pkt_ready = ($urandom_range(0, 3) != 0);
    if (pkt_valid && xfers == stall_at && stall_left > 0) begin
      pkt_ready = 1'b0;
      stall_left--;
    end
    if (pkt_valid && pkt_ready) begin
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 34'h0;
      check("pkt", pkt_data, exp);
      xfers++;
    end
    hold_v = pkt_valid && !pkt_ready;
    hold_d = pkt_data;
    @(posedge clk);
    @(negedge clk);
    if (hold_v) begin
      check("hold_valid", 34'(pkt_valid), 34'(1));
      check("hold_data", pkt_data, hold_d);
    end
    check("ready_busy_excl", 34'(ts_ready & busy), 34'(0));
    if (ts_done) done_seen = 1;
  endtask

  task automatic kwrite(input logic [1:0] idx, input logic [23:0] wd);
    flt_we = 1'b1; flt_idx = idx; flt_wdata = wd;
    if (idx != 2'd3) begin m_k[idx] = wd; m_dirty = 1; end
    tick();
    flt_we = 1'b0;
  endtask

  task automatic run_ts(input logic [24:0] ifm, input bit we, input logic [1:0] idx,
                        input logic [23:0] wd, input bit late_we, input int abort_after,
                        input bit lat_chk);
    int n;
    bit kern;
    n = 0;
    while (!ts_ready && n < 50) begin tick(); n++; end
    check("ts_ready_wait", 34'(ts_ready), 34'(1));
    ts_valid = 1'b1; ts_ifmap = ifm;
    flt_we = we; flt_idx = idx; flt_wdata = wd;
    if (we && idx != 2'd3) begin m_k[idx] = wd; m_dirty = 1; end
    kern = m_dirty;
    if (m_dirty)
      for (int i = 0; i < 3; i++) exp_q.push_back({SRC, k_dst[i], T_K, m_k[i]});
    for (int r = 0; r < 5; r++) exp_q.push_back({SRC, i_dst[r], T_IN, 19'b0, ifm[5*r +: 5]});
    m_dirty = 0;
    xfers = 0;
    done_seen = 0;
    tick();
    ts_valid = 1'b0; flt_we = 1'b0;
    ts_ifmap = 25'($urandom);
    n = 0;
    while (!done_seen && n < 200) begin
      if (abort_after >= 0 && xfers == abort_after && pkt_valid) return;
      if (late_we && n == 2) begin
        flt_we = 1'b1; flt_idx = 2'd0; flt_wdata = 24'($urandom);
      end
      tick();
      flt_we = 1'b0;
      n++;
    end
    check("ts_done_seen", 34'(done_seen), 34'(1));
    check("queue_drained", 34'(exp_q.size()), 34'(0));
    if (lat_chk) check("done_latency", 34'(n + 1), kern ? 34'(3 + 5 + 1) : 34'(5 + 1));
    tick();
    check("done_pulse", 34'(ts_done), 34'(0));
    check("back_idle", 34'(ts_ready), 34'(1));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m_k[i] = '0;
    m_dirty = 1;
    repeat (2) @(negedge clk);
    check("rst_pkt_valid", 34'(pkt_valid), 34'(0));
    check("rst_pkt_data", pkt_data, 34'(0));
    check("rst_ts_done", 34'(ts_done), 34'(0));
    check("rst_busy", 34'(busy), 34'(0));
    check("rst_ts_ready", 34'(ts_ready), 34'(0));
    reset = 1'b0;

    // Kernel load and first timestep with full-rate NoC.
    kwrite(2'd0, 24'hAABBCC);
    kwrite(2'd1, 24'h112233);
    kwrite(2'd2, 24'h445566);
    run_ts(25'h1555555, 0, 2'd0, 24'h0, 0, -1, 1);

    // Kernel unchanged: ifmap packets only.
    run_ts(25'($urandom), 0, 2'd0, 24'h0, 0, -1, 1);

    // Stall the second ifmap packet for four cycles.
    stall_at = 1; stall_left = 4;
    run_ts(25'($urandom), 0, 2'd0, 24'h0, 0, -1, 0);
    check("stall_applied", 34'(stall_left), 34'(0));
    stall_at = -1;

    // Same-cycle write resends the kernel; a write while busy is dropped.
    run_ts(25'($urandom), 1, 2'd1, 24'hC0FFEE, 1, -1, 1);
    run_ts(25'($urandom), 0, 2'd0, 24'h0, 0, -1, 1);

    // Reset on the third ifmap packet.
    run_ts(25'($urandom), 0, 2'd0, 24'h0, 0, 2, 0);
    reset = 1'b1;
    #1;
    check("abort_pkt_valid", 34'(pkt_valid), 34'(0));
    check("abort_busy", 34'(busy), 34'(0));
    check("abort_ts_ready", 34'(ts_ready), 34'(0));
    for (int i = 0; i < 3; i++) m_k[i] = '0;
    m_dirty = 1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    hold_v = 0;
    run_ts(25'($urandom), 0, 2'd0, 24'h0, 0, -1, 1);

    // Index 3 write must not mark the kernel dirty.
    kwrite(2'd3, 24'h123456);
    run_ts(25'($urandom), 0, 2'd0, 24'h0, 0, -1, 1);

    // Random backpressure and kernel traffic.
    ready_mode = 1;
    for (int t = 0; t < 50; t++) begin
      int nw;
      nw = int'($urandom_range(0, 2));
      for (int w = 0; w < nw; w++) kwrite(2'($urandom_range(0, 3)), 24'($urandom));
      run_ts(25'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
             24'($urandom), ($urandom_range(0, 1) == 1), -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
